// File: rtl/phys_reg_freelist_pkg.sv
// Shared types and sizing for the physical register free list.
package phys_reg_freelist_pkg;

    localparam int NUM_PHYS_REGS = 128;
    localparam int NUM_ARCH_REGS = 32;
    localparam int PREG_IDX_W    = 7;

    typedef logic [7:0]            PhyRegisterId_T;
    typedef logic [7:0]            FreeListPtr_T;
    typedef logic [PREG_IDX_W-1:0] PhyRegIdx_T;

endpackage

// File: rtl/freelist_ram.sv
// Free-list storage: asynchronous read, synchronous write, reset preloads
// entry i with INIT_BASE+i (truncated to the index width).
module freelist_ram
    import phys_reg_freelist_pkg::*;
#(
    parameter int DEPTH     = NUM_PHYS_REGS,
    parameter int IDX_W     = PREG_IDX_W,
    parameter int INIT_BASE = NUM_ARCH_REGS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [IDX_W-1:0] rdata_o,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [IDX_W-1:0] wdata_i
);

    logic [IDX_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= IDX_W'(INIT_BASE + i);
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/phys_reg_freelist.sv
// Circular free list of physical registers: speculative head for rename,
// committed head for one-cycle flush recovery, tail for ROB releases.
module phys_reg_freelist
    import phys_reg_freelist_pkg::*;
#(
    parameter int NUM_PHYS = NUM_PHYS_REGS,
    parameter int NUM_ARCH = NUM_ARCH_REGS,
    parameter int PTR_W    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           alloc_req,
    output logic           alloc_gnt,
    output PhyRegisterId_T alloc_preg,
    input  logic           commit_valid,
    input  logic           commit_has_dest,
    input  PhyRegisterId_T commit_old_preg,
    input  logic           flush,
    output FreeListPtr_T   free_count,
    output logic           empty,
    output logic           err
);

    logic [PTR_W-1:0] spec_head_q, spec_head_d;
    logic [PTR_W-1:0] commit_head_q, commit_head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic             err_q, err_d;

    logic [PTR_W-2:0] rd_idx;
    logic [PTR_W-1:0] fc;
    logic             legal, bad_tag, none_out, ovf, rel;

    freelist_ram #(
        .DEPTH     (NUM_PHYS),
        .IDX_W     (PTR_W-1),
        .INIT_BASE (NUM_ARCH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr_i (spec_head_q[PTR_W-2:0]),
        .rdata_o (rd_idx),
        .we_i    (rel),
        .waddr_i (tail_q[PTR_W-2:0]),
        .wdata_i (commit_old_preg[PTR_W-2:0])
    );

    always_comb begin
        fc         = tail_q - spec_head_q;
        free_count = FreeListPtr_T'(fc);
        empty      = (fc == '0);
        err        = err_q;
        alloc_gnt  = rst_n & alloc_req & ~empty & ~flush;
        alloc_preg = alloc_gnt ? {1'b1, rd_idx} : '0;

        bad_tag  = commit_valid & commit_has_dest & ~commit_old_preg[7];
        legal    = commit_valid & commit_has_dest &  commit_old_preg[7];
        none_out = legal & (commit_head_q == spec_head_q);
        // A release with no same-cycle grant would push the pool past full.
        ovf      = legal & ~none_out & ~alloc_gnt & (fc == PTR_W'(NUM_PHYS));
        rel      = legal & ~none_out & ~ovf;

        commit_head_d = commit_head_q + PTR_W'(rel);
        tail_d        = tail_q + PTR_W'(rel);
        spec_head_d   = flush ? commit_head_d : spec_head_q + PTR_W'(alloc_gnt);
        err_d         = err_q | bad_tag | none_out | ovf;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spec_head_q   <= '0;
            commit_head_q <= '0;
            tail_q        <= PTR_W'(NUM_PHYS - NUM_ARCH);
            err_q         <= 1'b0;
        end else begin
            spec_head_q   <= spec_head_d;
            commit_head_q <= commit_head_d;
            tail_q        <= tail_d;
            err_q         <= err_d;
        end
    end

endmodule

// File: tb/tb_phys_reg_freelist.sv
// Directed vector table, corner-case sequences and a queue-based random model.
module tb_phys_reg_freelist;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alloc_req;
    logic       alloc_gnt;
    logic [7:0] alloc_preg;
    logic       commit_valid;
    logic       commit_has_dest;
    logic [7:0] commit_old_preg;
    logic       flush;
    logic [7:0] free_count;
    logic       empty;
    logic       err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    phys_reg_freelist dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alloc_req       (alloc_req),
        .alloc_gnt       (alloc_gnt),
        .alloc_preg      (alloc_preg),
        .commit_valid    (commit_valid),
        .commit_has_dest (commit_has_dest),
        .commit_old_preg (commit_old_preg),
        .flush           (flush),
        .free_count      (free_count),
        .empty           (empty),
        .err             (err)
    );

    typedef struct {
        logic       areq;
        logic       cv;
        logic       cd;
        logic [7:0] cold;
        logic       fl;
        logic       egnt;
        logic [7:0] epreg;
        logic [7:0] efc;
        logic       eempty;
        logic       eerr;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic a, input logic cv, input logic cd,
                         input logic [7:0] co, input logic fl);
        alloc_req       = a;
        commit_valid    = cv;
        commit_has_dest = cd;
        commit_old_preg = co;
        flush           = fl;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        chk("reset gnt forced low", int'(alloc_gnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        chk("reset free_count", int'(free_count), 96);
        chk("reset empty", int'(empty), 0);
        chk("reset err", int'(err), 0);
    endtask

    // Queue model for the random phase
    int unsigned free_q [$];
    int unsigned outs_q [$];
    bit          inuse [128];
    int unsigned amap [32];

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'd96, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA0, 8'd96, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA1, 8'd95, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'd94, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA0, 8'd96, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA1, 8'd95, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'h90, 1'b0, 1'b0, 8'h00, 8'd94, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA2, 8'd95, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 8'h91, 1'b0, 1'b1, 8'hA3, 8'd94, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'd94, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 8'h92, 1'b1, 1'b0, 8'h00, 8'd94, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'd96, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA3, 8'd96, 1'b0, 1'b0};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // Vector table
        do_reset();
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i].areq, vecs[i].cv, vecs[i].cd, vecs[i].cold, vecs[i].fl);
            #1;
            chk($sformatf("vec%0d gnt", i), int'(alloc_gnt), int'(vecs[i].egnt));
            chk($sformatf("vec%0d preg", i), int'(alloc_preg), int'(vecs[i].epreg));
            chk($sformatf("vec%0d free_count", i), int'(free_count), int'(vecs[i].efc));
            chk($sformatf("vec%0d empty", i), int'(empty), int'(vecs[i].eempty));
            chk($sformatf("vec%0d err", i), int'(err), int'(vecs[i].eerr));
        end

        // Drain all 96 entries, then hit empty
        do_reset();
        for (int i = 0; i < 96; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            #1;
            chk($sformatf("drain gnt %0d", i), int'(alloc_gnt), 1);
            chk($sformatf("drain preg %0d", i), int'(alloc_preg), 'hA0 + i);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        chk("empty gnt", int'(alloc_gnt), 0);
        chk("empty flag", int'(empty), 1);
        chk("empty free_count", int'(free_count), 0);

        // Release into an empty list: no bypass, grantable next cycle
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 8'h85, 1'b0);
        #1;
        chk("empty+release gnt", int'(alloc_gnt), 0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        chk("released gnt", int'(alloc_gnt), 1);
        chk("released preg", int'(alloc_preg), 'h85);

        // 10 allocs, 3 commits, flush
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 1'b1, 8'(8'h80 + i), 1'b0);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        chk("flush free_count", int'(free_count), 96);
        chk("flush spec_head", int'(dut.spec_head_q), 3);
        chk("flush commit_head", int'(dut.commit_head_q), 3);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        chk("post-flush preg", int'(alloc_preg), 'hA3);

        // Flush, alloc and legal commit together
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 8'h83, 1'b1);
        #1;
        chk("flush+commit gnt", int'(alloc_gnt), 0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        chk("flush+commit spec_head", int'(dut.spec_head_q), 4);
        chk("flush+commit commit_head", int'(dut.commit_head_q), 4);
        chk("flush+commit free_count", int'(free_count), 96);

        // Release with the valid bit clear
        do_reset();
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 8'h05, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        chk("bad tag err", int'(err), 1);
        chk("bad tag tail", int'(dut.tail_q), 96);
        repeat (3) @(negedge clk);
        #1;
        chk("bad tag err sticky", int'(err), 1);
        do_reset();

        // Legal commit with nothing outstanding
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 8'h80, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        chk("no-outstanding err", int'(err), 1);
        chk("no-outstanding tail", int'(dut.tail_q), 96);
        chk("no-outstanding free_count", int'(free_count), 96);
        do_reset();

        // Random traffic against the queue model
        do_reset();
        free_q.delete();
        outs_q.delete();
        for (int unsigned i = 0; i < 128; i++) begin
            inuse[i] = (i < 32);
            if (i >= 32) free_q.push_back(i);
        end
        for (int unsigned i = 0; i < 32; i++) amap[i] = i;

        for (int cyc = 0; cyc < 10000 && failures < 50; cyc++) begin
            logic        a, fl, dc, nd, eg;
            int unsigned rd, g, p, old, x;
            @(negedge clk);
            a  = ($urandom_range(0, 9) < 7);
            fl = ($urandom_range(0, 99) < 3);
            dc = (outs_q.size() > 0) && ($urandom_range(0, 1) == 1);
            nd = !dc && ($urandom_range(0, 3) == 0);
            rd = $urandom_range(0, 31);
            if (dc)      drive(a, 1'b1, 1'b1, {1'b1, 7'(amap[rd])}, fl);
            else if (nd) drive(a, 1'b1, 1'b0, 8'($urandom), fl);
            else         drive(a, 1'b0, 1'b0, 8'h00, fl);
            #1;
            eg = a && !fl && (free_q.size() > 0);
            chk("rand gnt", int'(alloc_gnt), int'(eg));
            chk("rand preg", int'(alloc_preg), eg ? int'(128 + free_q[0]) : 0);
            chk("rand free_count", int'(free_count), int'(free_q.size()));
            chk("rand err", int'(err), 0);
            chk("rand invariant", int'(8'(dut.tail_q - dut.commit_head_q)), 96);
            if (eg) begin
                g = free_q.pop_front();
                chk("rand double grant", int'(inuse[g]), 0);
                inuse[g] = 1'b1;
                outs_q.push_back(g);
            end
            if (dc) begin
                p        = outs_q.pop_front();
                old      = amap[rd];
                amap[rd] = p;
                free_q.push_back(old);
                inuse[old] = 1'b0;
            end
            if (fl) begin
                while (outs_q.size() > 0) begin
                    x = outs_q.pop_back();
                    free_q.push_front(x);
                    inuse[x] = 1'b0;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/phys_reg_freelist.md
Name: phys_reg_freelist

Overview:
- Manages the pool of free physical registers for the rename stage of the RV64 out-of-order core.
- Grants one free physical register per cycle to rename.
- Takes back one superseded physical register per cycle from ROB commit.
- Keeps a committed head pointer so a pipeline flush restores the free pool in one cycle.
- Sits between the rename map table (allocation side) and the ROB retire logic (release side).

Parameters:
- NUM_PHYS, 128, physical register count; equals 2^7 so the index fits PhyRegisterId_T[6:0]
- NUM_ARCH, 32, architectural registers; physical registers 0..NUM_ARCH-1 are mapped at reset, so they are not free
- PTR_W, 8, pointer width: 7-bit index plus 1 wrap bit

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, synchronous, active-low
- alloc_req  in  1  rename needs one destination physical register this cycle
- alloc_gnt  out  1  allocation accepted this cycle
- alloc_preg  out  8  PhyRegisterId_T; bit7 = alloc_gnt, bits 6:0 = granted index
- commit_valid  in  1  ROB retires one instruction this cycle
- commit_has_dest  in  1  the retiring instruction wrote a destination register
- commit_old_preg  in  8  PhyRegisterId_T of the superseded mapping; bit7 must be 1
- flush  in  1  squash all speculative allocations
- free_count  out  8  speculatively free entries, 0..128
- empty  out  1  free_count == 0
- err  out  1  sticky protocol-violation flag

Behaviour:
One clock domain. Reset is synchronous and active-low: all state updates on the rising edge of clk while rst_n=0.

State:
- storage ram[0:127] of 7-bit indices
- spec_head, commit_head, tail: each PTR_W bits
- err_q

Reset (rst_n=0 at an edge):
- ram[i] = NUM_ARCH+i for i in 0..95
- spec_head = commit_head = 0, tail = 96, err_q = 0
- result after the edge: free_count = 96, empty = 0, err = 0
- alloc_gnt is forced to 0 while rst_n=0

Definitions:
- free_count = tail - spec_head, modulo 2^PTR_W
- empty = (free_count == 0)

Allocation (combinational grant, zero latency):
- alloc_gnt = rst_n & alloc_req & ~empty & ~flush
- alloc_preg = {alloc_gnt, ram[spec_head[6:0]]}; it is 8'h00 when alloc_gnt=0
- on an edge with alloc_gnt=1: spec_head += 1

Release (a legal commit is commit_valid & commit_has_dest & commit_old_preg[7]):
- ram[tail[6:0]] <= commit_old_preg[6:0]
- tail += 1
- commit_head += 1, because the retiring instruction's own register was allocated at commit_head
- commit_valid with commit_has_dest=0 changes nothing

Same-cycle alloc and release:
- both take effect
- alloc reads the pre-write ram, with no bypass
- if the list is empty that cycle, alloc_gnt=0 and the released entry is grantable from the next cycle
- free_count is unchanged net

Flush:
- spec_head <= commit_head + (1 if a legal commit occurs in the same cycle), i.e. the commit is applied first
- the release write and tail update still happen
- alloc is suppressed
- the next cycle shows free_count = tail_new - commit_head_new

Invariants:
- tail - commit_head == NUM_PHYS - NUM_ARCH (96) at all times
- commit_head <= spec_head <= tail, in modular order

err is set, and stays set until reset, when any of these occur:
- a commit with commit_has_dest=1 and commit_old_preg[7]=0; the release is ignored
- a legal commit while commit_head == spec_head, i.e. nothing outstanding; the release is ignored
- free_count would exceed 128

Pointer wrap: indices wrap 127 -> 0; the wrap bit toggles; no special handling is needed.

Decomposition:
- Add to package Type:
  - NUM_PHYS_REGS = 128, NUM_ARCH_REGS = 32
  - typedef logic[7:0] FreeListPtr_T
  - reuse PhyRegisterId_T
- One sub-module: freelist_ram. It is 128x7, one asynchronous read port plus one synchronous write port, and takes a reset-init of ram[i] = 32+i.
- Pointer and control logic stays in phys_reg_freelist.

Test Plan:
1. Reset, then alloc_req=1 for 96 cycles:
   - grants 8'h A0, 8'h A1, ... 8'h FF in order
   - cycle 97: alloc_gnt=0, empty=1, free_count=0
2. From the empty state, one legal commit with commit_old_preg=8'h85 and alloc_req=1 in the same cycle:
   - that cycle: alloc_gnt=0
   - next cycle: alloc_gnt=1, alloc_preg=8'h85
3. After reset, 10 allocations, then 3 commits (old pregs 8'h80, 8'h81, 8'h82), then flush:
   - next cycle: free_count=96
   - spec_head == commit_head == 3
   - next alloc returns 8'h A3
4. flush and alloc_req in the same cycle as a legal commit:
   - alloc_gnt=0
   - spec_head equals the incremented commit_head
   - free_count=96 next cycle
5. Commit with commit_has_dest=1 and commit_old_preg=8'h05 (valid bit clear):
   - err=1 next cycle and stays 1
   - tail unchanged
   - rst_n=0 for one edge clears err
6. Random 10k cycles of alloc, commit and flush against a scoreboard model:
   - the 96-entry invariant holds throughout
   - no index is granted twice while outstanding
   - err stays 0
